// File: rtl/carry_lookahead_adder.sv
// Two-level carry-lookahead adder: 4-bit lookahead groups chained into 16-bit super-blocks,
// with a combinational sum/carry, block generate/propagate, and a one-cycle registered copy.
module carry_lookahead_adder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   output logic [WIDTH-1:0] S,
   output logic             C_out,
   output logic             G_out,
   output logic             P_out,
   output logic [WIDTH-1:0] S_q,
   output logic             C_out_q
);

   localparam int GROUP = 4;
   localparam int NG    = WIDTH / GROUP;
   localparam int NSB   = (NG + 3) / 4;
   localparam int NGP   = NSB * 4;

   if (WIDTH % GROUP != 0 || WIDTH < GROUP) begin : g_bad_width
      $error("carry_lookahead_adder: WIDTH must be a positive multiple of 4");
   end

   // Carries into positions 1..3 of a 4-wide lookahead unit, flat sum-of-products.
   function automatic logic [2:0] cla_carries(input logic [3:0] g, input logic [3:0] p,
                                              input logic ci);
      logic c1, c2, c3;
      c1 = g[0] | (p[0] & ci);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      return {c3, c2, c1};
   endfunction

   function automatic logic cla_gen(input logic [3:0] g, input logic [3:0] p);
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   // Generate of the span [0, n) of super-blocks, expanded as an OR of product terms.
   function automatic logic span_gen(input logic [NSB-1:0] gv, input logic [NSB-1:0] pv,
                                     input int n);
      logic acc, term;
      acc = 1'b0;
      for (int i = 0; i < NSB; i++) begin
         if (i < n) begin
            term = gv[i];
            for (int j = i + 1; j < NSB; j++) begin
               if (j < n) term = term & pv[j];
            end
            acc = acc | term;
         end
      end
      return acc;
   endfunction

   function automatic logic span_prop(input logic [NSB-1:0] pv, input int n);
      logic acc;
      acc = 1'b1;
      for (int i = 0; i < NSB; i++) begin
         if (i < n) acc = acc & pv[i];
      end
      return acc;
   endfunction

   logic [WIDTH-1:0] g, p, c;
   logic [NGP-1:0]   gg, gp, gc;
   logic [NSB-1:0]   sg, sp, sc;

   assign g = A & B;
   assign p = A ^ B;

   for (genvar k = 0; k < NG; k++) begin : g_group
      assign gg[k]              = cla_gen(g[GROUP*k +: GROUP], p[GROUP*k +: GROUP]);
      assign gp[k]              = &p[GROUP*k +: GROUP];
      assign c[GROUP*k]         = gc[k];
      assign c[GROUP*k+1 +: 3]  = cla_carries(g[GROUP*k +: GROUP], p[GROUP*k +: GROUP], gc[k]);
   end

   // Missing groups in a partial top super-block are made transparent (no generate, full propagate).
   for (genvar k = NG; k < NGP; k++) begin : g_pad
      assign gg[k] = 1'b0;
      assign gp[k] = 1'b1;
   end

   for (genvar s = 0; s < NSB; s++) begin : g_super
      assign sg[s]        = cla_gen(gg[4*s +: 4], gp[4*s +: 4]);
      assign sp[s]        = &gp[4*s +: 4];
      assign gc[4*s]      = sc[s];
      assign gc[4*s+1 +: 3] = cla_carries(gg[4*s +: 4], gp[4*s +: 4], sc[s]);
   end

   always_comb begin
      sc    = '0;
      sc[0] = C_in;
      for (int j = 1; j < NSB; j++) begin
         sc[j] = span_gen(sg, sp, j) | (span_prop(sp, j) & C_in);
      end
      G_out = span_gen(sg, sp, NSB);
      P_out = span_prop(sp, NSB);
   end

   assign S     = p ^ c;
   assign C_out = G_out | (P_out & C_in);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         S_q     <= '0;
         C_out_q <= 1'b0;
      end else begin
         S_q     <= S;
         C_out_q <= C_out;
      end
   end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Randomized and directed self-checking bench for carry_lookahead_adder against an
// arithmetic reference (A+B+C_in as a 33-bit sum).
module tb_carry_lookahead_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] A, B;
   logic        C_in;
   logic [31:0] S, S_q;
   logic        C_out, G_out, P_out, C_out_q;

   int n_cmp = 0;
   int n_err = 0;

   logic [32:0] exp_sum;
   logic [32:0] prev_sum;

   carry_lookahead_adder #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .A       (A),
      .B       (B),
      .C_in    (C_in),
      .S       (S),
      .C_out   (C_out),
      .G_out   (G_out),
      .P_out   (P_out),
      .S_q     (S_q),
      .C_out_q (C_out_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (A=%h B=%h C_in=%b)", tag, got, want, A, B, C_in);
      end
   endtask

   // Drive operands, then compare the combinational outputs with the arithmetic reference.
   task automatic drive_check(input logic [31:0] a, input logic [31:0] b, input logic ci);
      logic [32:0] no_cin;
      A = a;
      B = b;
      C_in = ci;
      #1;
      exp_sum = {1'b0, a} + {1'b0, b} + {32'd0, ci};
      no_cin  = {1'b0, a} + {1'b0, b};
      check("sum", {31'd0, C_out, S}, {31'd0, exp_sum});
      check("gen", {63'd0, G_out}, {63'd0, no_cin[32]});
      check("prop", {63'd0, P_out}, {63'd0, &(a ^ b)});
      check("cout_inv", {63'd0, C_out}, {63'd0, no_cin[32] | ((&(a ^ b)) & ci)});
   endtask

   task automatic check_reg(input string tag, input logic [32:0] want);
      check(tag, {31'd0, C_out_q, S_q}, {31'd0, want});
   endtask

   logic [31:0] dir_a [8] = '{32'h0, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h0000FFFF, 32'h0000000F, 32'h7FFFFFFF};
   logic [31:0] dir_b [8] = '{32'h0, 32'h7, 32'h0, 32'h0, 32'hFFFFFFFF,
                              32'h1, 32'h1, 32'h1};
   logic        dir_c [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      rst  = 1'b1;
      A    = '0;
      B    = '0;
      C_in = 1'b0;
      #2;
      check_reg("reset_state", 33'd0);
      @(posedge clk);
      #1;
      check_reg("reset_held", 33'd0);

      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive_check(dir_a[i], dir_b[i], dir_c[i]);
         @(posedge clk);
         #1;
         check_reg("reg_directed", exp_sum);
      end

      // Asynchronous reset well away from any rising edge; S_q holds a nonzero value here.
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reg("async_reset", 33'd0);
      drive_check(32'd1000, 32'd234, 1'b1);
      @(posedge clk);
      #1;
      check_reg("reset_over_edge", 33'd0);

      @(negedge clk);
      rst = 1'b0;
      drive_check(32'd100, 32'd23, 1'b0);
      check_reg("pre_capture", 33'd0);
      @(posedge clk);
      #1;
      check_reg("first_capture", 33'd123);

      // Back-to-back random operands: S_q must trail the combinational result by one cycle.
      @(negedge clk);
      prev_sum = 33'd123;
      for (int i = 0; i < 12000; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom();
         rb = $urandom();
         if (i < 10000) begin
            ra = ra & 32'h7FFFFFFF;
            rb = rb & 32'h7FFFFFFF;
         end
         check_reg("reg_lag", prev_sum);
         drive_check(ra, rb, 1'($urandom_range(1)));
         prev_sum = exp_sum;
         @(negedge clk);
      end
      check_reg("reg_lag_last", prev_sum);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/carry_lookahead_adder.md
Name: carry_lookahead_adder

Overview:
- 32-bit two-level carry-lookahead adder: 4-bit lookahead groups plus a second-level group-carry unit.
- Gives a combinational sum/carry-out, a registered copy of both, and block generate/propagate outputs for cascading.
- Used as the fast adder primitive in datapaths that need an unsigned A+B+C_in without ripple-carry delay.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 (one lookahead group per 4 bits).
- GROUP, 4, bits per first-level lookahead group; fixed at 4, not overridable.

Ports:
- clk  input  1  clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- C_in  input  1  carry into bit 0.
- S  output  WIDTH  combinational sum bits (A+B+C_in) mod 2^WIDTH.
- C_out  output  1  combinational carry out of bit WIDTH-1.
- G_out  output  1  block generate: the block produces a carry independent of C_in.
- P_out  output  1  block propagate: all bits propagate, i.e. A^B all ones.
- S_q  output  WIDTH  registered S.
- C_out_q  output  1  registered C_out.

Behaviour:
- Bit level: g[i]=A[i]&B[i]; p[i]=A[i]^B[i]; s[i]=p[i]^c[i]; c[0]=C_in.
- Group level, per 4-bit group k:
  - GG[k]=g3 | p3g2 | p3p2g1 | p3p2p1g0.
  - GP[k]=p3&p2&p1&p0.
  - Carries inside a group are computed in two-level sum-of-products form from the group carry-in, never rippled.
- Second level:
  - Group carry-ins are computed by lookahead across GG/GP.
  - Groups are chained in 4-group (16-bit) super-blocks; super-block carries use the same lookahead equations.
  - Nothing ripples bit by bit.
- C_out is the carry into bit WIDTH, i.e. {C_out,S} = A+B+C_in exactly, as a (WIDTH+1)-bit result.
- G_out and P_out are the top-level block generate/propagate.
  - Invariant: C_out == G_out | (P_out & C_in).
- S, C_out, G_out and P_out are purely combinational from A, B and C_in. They do not depend on clk or rst.
- Registered path:
  - On each rising clk, S_q<=S and C_out_q<=C_out.
  - Latency is 1 cycle; there is no enable and no handshake. A new operand pair is accepted every cycle.
- Reset:
  - While rst=1, S_q=0 and C_out_q=0 immediately, regardless of clk.
  - rst is deasserted synchronously to clk by the integration; the first capture happens on the first rising edge with rst=0.
  - rst has no effect on the combinational outputs.
- Overflow: the sum wraps modulo 2^WIDTH; the overflow is reported only through C_out. There is no saturation and no signed overflow flag.
- Any X or Z on an operand bit may propagate to the dependent S bits and carries. No masking is required.

Test Plan:
- All-zero and basic: A=0, B=0, C_in=0 -> S=0, C_out=0, G_out=0, P_out=0. Then A=5, B=7, C_in=0 -> S=12, C_out=0.
- Full carry chain:
  - A=32'hFFFFFFFF, B=0, C_in=1 -> S=0, C_out=1, P_out=1, G_out=0.
  - Same operands with C_in=0 -> S=32'hFFFFFFFF, C_out=0.
- Generate and wrap: A=32'hFFFFFFFF, B=32'hFFFFFFFF, C_in=0 -> S=32'hFFFFFFFE, C_out=1, G_out=1.
- Group and super-block boundaries:
  - A=32'h0000FFFF, B=1 -> S=32'h00010000, C_out=0.
  - A=32'h0000000F, B=1 -> S=32'h00000010.
  - A=32'h7FFFFFFF, B=1 -> S=32'h80000000, C_out=0.
- Register path and reset:
  - Assert rst mid-run -> S_q=0 and C_out_q=0 with no clock edge.
  - Release rst, apply A=100, B=23 -> S=123 immediately; S_q=123 after the next rising clk.
- Random regression: at least 10000 random pairs with 31-bit operands and random C_in, comparing {C_out,S} against the reference A+B+C_in. Also check C_out==G_out|(P_out&C_in) and the 1-cycle S_q lag.
